// File: rtl/psg_bus_sequencer.sv
// Round-robin sequencer sharing one YM2149 register bus between requesters.
// Drives BDIR/BC/DI through address-latch and access phases per request.
module psg_bus_sequencer #(
   parameter int NREQ      = 2,
   parameter int PHASE_CYC = 1,
   parameter bit SKIP_ADDR = 1'b1
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [NREQ-1:0]   REQ_VALID,
   input  logic [NREQ-1:0]   REQ_WR,
   input  logic [4*NREQ-1:0] REQ_ADDR,
   input  logic [8*NREQ-1:0] REQ_DATA,
   output logic [NREQ-1:0]   REQ_READY,
   output logic [NREQ-1:0]   RSP_VALID,
   output logic [7:0]        RSP_DATA,
   output logic              PSG_BDIR,
   output logic              PSG_BC,
   output logic [7:0]        PSG_DI,
   input  logic [7:0]        PSG_DO,
   output logic              BUSY
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [3:0] PH_LAST = 4'(PHASE_CYC - 1);

   typedef logic [IW-1:0] idx_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_ACCESS,
      S_GAP
   } state_t;

   state_t     state_q;
   state_t     state_d;
   idx_t       ptr_q;
   idx_t       own_q;
   logic       wr_q;
   logic [3:0] addr_q;
   logic [7:0] data_q;
   logic [3:0] cnt_q;
   logic [3:0] shadow_q;
   logic       shadow_vld_q;

   logic       hi_any;
   logic       lo_any;
   idx_t       hi_idx;
   idx_t       lo_idx;
   logic       gnt_any;
   idx_t       gnt_idx;
   logic       sel_wr;
   logic [3:0] sel_addr;
   logic [7:0] sel_data;
   logic       rdy_en;
   logic       rsp_en;
   logic       phase_last;
   logic       addr_hit;

   // First valid at or above the pointer wins; otherwise wrap to the lowest.
   always_comb begin
      hi_any = 1'b0;
      lo_any = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (REQ_VALID[i]) begin
            lo_any = 1'b1;
            lo_idx = idx_t'(i);
            if (idx_t'(i) >= ptr_q) begin
               hi_any = 1'b1;
               hi_idx = idx_t'(i);
            end
         end
      end
      gnt_any = hi_any | lo_any;
      gnt_idx = hi_any ? hi_idx : lo_idx;
   end

   always_comb begin
      sel_wr   = 1'b0;
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_idx == idx_t'(i)) begin
            sel_wr   = REQ_WR[i];
            sel_addr = REQ_ADDR[4*i +: 4];
            sel_data = REQ_DATA[8*i +: 8];
         end
      end
   end

   assign phase_last = (cnt_q == PH_LAST);
   assign addr_hit   = SKIP_ADDR && shadow_vld_q && (shadow_q == sel_addr);
   assign BUSY       = (state_q != S_IDLE);

   always_comb begin
      state_d  = state_q;
      rdy_en   = 1'b0;
      rsp_en   = 1'b0;
      PSG_BDIR = 1'b0;
      PSG_BC   = 1'b0;
      PSG_DI   = 8'h00;
      unique case (state_q)
         S_IDLE: begin
            if (gnt_any && !RESET) begin
               rdy_en  = 1'b1;
               state_d = addr_hit ? S_ACCESS : S_ADDR;
            end
         end
         S_ADDR: begin
            PSG_BDIR = 1'b1;
            PSG_BC   = 1'b1;
            PSG_DI   = {4'h0, addr_q};
            if (phase_last) state_d = S_ACCESS;
         end
         S_ACCESS: begin
            // Writes are a single pulse so a reg 13 write restarts the envelope once.
            if (wr_q) begin
               PSG_BDIR = 1'b1;
               PSG_DI   = data_q;
               state_d  = S_GAP;
            end else begin
               PSG_BC = 1'b1;
               if (phase_last) state_d = S_GAP;
            end
         end
         S_GAP: begin
            rsp_en  = !RESET;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      REQ_READY = '0;
      RSP_VALID = '0;
      for (int i = 0; i < NREQ; i++) begin
         REQ_READY[i] = rdy_en && (gnt_idx == idx_t'(i));
         RSP_VALID[i] = rsp_en && (own_q == idx_t'(i));
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         own_q        <= '0;
         wr_q         <= 1'b0;
         addr_q       <= '0;
         data_q       <= '0;
         cnt_q        <= '0;
         shadow_q     <= '0;
         shadow_vld_q <= 1'b0;
         RSP_DATA     <= 8'hFF;
      end else begin
         state_q <= state_d;
         if (state_d == state_q && state_q != S_IDLE) begin
            cnt_q <= cnt_q + 4'd1;
         end else begin
            cnt_q <= '0;
         end
         if (rdy_en) begin
            own_q  <= gnt_idx;
            wr_q   <= sel_wr;
            addr_q <= sel_addr;
            data_q <= sel_data;
            ptr_q  <= (gnt_idx == idx_t'(NREQ - 1)) ? '0 : gnt_idx + idx_t'(1);
         end
         if (state_q == S_ADDR) begin
            shadow_q     <= addr_q;
            shadow_vld_q <= 1'b1;
         end
         if (state_q == S_ACCESS) begin
            if (wr_q) begin
               RSP_DATA <= 8'hFF;
            end else if (phase_last) begin
               RSP_DATA <= PSG_DO;
            end
         end
      end
   end

   a_ready_onehot : assert property (@(posedge CLK) $onehot0(REQ_READY));
   a_rsp_onehot   : assert property (@(posedge CLK) $onehot0(RSP_VALID));
   a_di_idle      : assert property (@(posedge CLK) !PSG_BDIR |-> PSG_DI == 8'h00);

endmodule

// File: tb/tb_psg_bus_sequencer.sv
// Scoreboard bench: expected per-cycle bus/handshake records are queued at
// issue time and popped by monitors whenever a DUT shows activity.
module tb_psg_bus_sequencer;

   logic CLK = 1'b0;
   logic RESET = 1'b1;
   always #5 CLK = ~CLK;

   logic [1:0]  va = '0, wa = '0, rdy_a, rv_a;
   logic [7:0]  aa = '0;
   logic [15:0] da = '0;
   logic [7:0]  rd_a, di_a, do_a = '0;
   logic        bdir_a, bc_a, busy_a;

   logic [1:0]  vb = '0, wb = '0, rdy_b, rv_b;
   logic [7:0]  ab = '0;
   logic [15:0] db = '0;
   logic [7:0]  rd_b, di_b, do_b = '0;
   logic        bdir_b, bc_b, busy_b;

   psg_bus_sequencer #(.NREQ(2), .PHASE_CYC(1), .SKIP_ADDR(1'b1)) dut_a (
      .CLK(CLK), .RESET(RESET),
      .REQ_VALID(va), .REQ_WR(wa), .REQ_ADDR(aa), .REQ_DATA(da),
      .REQ_READY(rdy_a), .RSP_VALID(rv_a), .RSP_DATA(rd_a),
      .PSG_BDIR(bdir_a), .PSG_BC(bc_a), .PSG_DI(di_a), .PSG_DO(do_a),
      .BUSY(busy_a));

   psg_bus_sequencer #(.NREQ(2), .PHASE_CYC(3), .SKIP_ADDR(1'b1)) dut_b (
      .CLK(CLK), .RESET(RESET),
      .REQ_VALID(vb), .REQ_WR(wb), .REQ_ADDR(ab), .REQ_DATA(db),
      .REQ_READY(rdy_b), .RSP_VALID(rv_b), .RSP_DATA(rd_b),
      .PSG_BDIR(bdir_b), .PSG_BC(bc_b), .PSG_DI(di_b), .PSG_DO(do_b),
      .BUSY(busy_b));

   typedef struct packed {
      logic [1:0] rdy;
      logic       bdir;
      logic       bc;
      logic [7:0] di;
      logic [1:0] rv;
      logic [7:0] rd;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int   n_chk = 0;
   int   n_fail = 0;

   function automatic string fmt(exp_t e);
      return $sformatf("rdy=%b bdir=%b bc=%b di=%h rv=%b rd=%h",
                       e.rdy, e.bdir, e.bc, e.di, e.rv, e.rd);
   endfunction

   function automatic void put(bit sel, exp_t e);
      if (sel) qb.push_back(e);
      else qa.push_back(e);
   endfunction

   function automatic void push_txn(bit sel, int g, bit wr, logic [3:0] a,
                                    logic [7:0] d, logic [7:0] rd, bit skip,
                                    int ph);
      logic [1:0] oh;
      oh = 2'(1 << g);
      put(sel, '{rdy: oh, bdir: 0, bc: 0, di: 0, rv: 0, rd: 0});
      if (!skip)
         for (int i = 0; i < ph; i++)
            put(sel, '{rdy: 0, bdir: 1, bc: 1, di: {4'h0, a}, rv: 0, rd: 0});
      if (wr)
         put(sel, '{rdy: 0, bdir: 1, bc: 0, di: d, rv: 0, rd: 0});
      else
         for (int i = 0; i < ph; i++)
            put(sel, '{rdy: 0, bdir: 0, bc: 1, di: 0, rv: 0, rd: 0});
      put(sel, '{rdy: 0, bdir: 0, bc: 0, di: 0, rv: oh,
                 rd: wr ? 8'hFF : rd});
   endfunction

   always @(negedge CLK) begin : mon_a
      exp_t act;
      exp_t e;
      if (busy_a || |rdy_a || |rv_a || bdir_a || bc_a) begin
         act = '{rdy: rdy_a, bdir: bdir_a, bc: bc_a, di: di_a, rv: rv_a,
                 rd: (|rv_a) ? rd_a : 8'h00};
         n_chk++;
         if (qa.size() == 0) begin
            n_fail++;
            $display("FAIL A_unexpected: got %s, want no activity", fmt(act));
         end else begin
            e = qa.pop_front();
            if (act !== e) begin
               n_fail++;
               $display("FAIL A_cycle @%0t: got %s, want %s", $time,
                        fmt(act), fmt(e));
            end
         end
      end
   end

   always @(negedge CLK) begin : mon_b
      exp_t act;
      exp_t e;
      if (busy_b || |rdy_b || |rv_b || bdir_b || bc_b) begin
         act = '{rdy: rdy_b, bdir: bdir_b, bc: bc_b, di: di_b, rv: rv_b,
                 rd: (|rv_b) ? rd_b : 8'h00};
         n_chk++;
         if (qb.size() == 0) begin
            n_fail++;
            $display("FAIL B_unexpected: got %s, want no activity", fmt(act));
         end else begin
            e = qb.pop_front();
            if (act !== e) begin
               n_fail++;
               $display("FAIL B_cycle @%0t: got %s, want %s", $time,
                        fmt(act), fmt(e));
            end
         end
      end
   end

   // Distinct DO per read-access cycle so a wrong sample cycle is visible.
   int acc_b = 0;
   always @(negedge CLK) begin
      if (!bdir_b && bc_b) begin
         acc_b = acc_b + 1;
         do_b = (acc_b == 3) ? 8'h5A : 8'(8'h10 + acc_b);
      end else begin
         acc_b = 0;
         do_b = 8'h00;
      end
   end

   task automatic wait_ready(input bit sel, input int g);
      logic [1:0] r;
      bit got;
      got = 0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge CLK);
         r = sel ? rdy_b : rdy_a;
         if (r[g]) got = 1;
      end
      n_chk++;
      if (!got) begin
         n_fail++;
         $display("FAIL ready_timeout: got no READY[%0d], want READY", g);
      end
   endtask

   task automatic wait_idle(input bit sel);
      bit idle;
      idle = 0;
      for (int i = 0; i < 40 && !idle; i++) begin
         @(negedge CLK);
         idle = sel ? !busy_b : !busy_a;
      end
      n_chk++;
      if (!idle) begin
         n_fail++;
         $display("FAIL idle_timeout: got BUSY=1, want 0");
      end
   endtask

   task automatic txn(input bit sel, input int g, input bit wr,
                      input logic [3:0] a, input logic [7:0] d,
                      input logic [7:0] rd, input bit skip);
      push_txn(sel, g, wr, a, d, rd, skip, sel ? 3 : 1);
      @(posedge CLK); #1;
      if (sel) begin
         vb[g] = 1'b1; wb[g] = wr; ab[4*g +: 4] = a; db[8*g +: 8] = d;
      end else begin
         va[g] = 1'b1; wa[g] = wr; aa[4*g +: 4] = a; da[8*g +: 8] = d;
         do_a = rd;
      end
      wait_ready(sel, g);
      @(posedge CLK); #1;
      if (sel) vb = '0;
      else va = '0;
      wait_idle(sel);
   endtask

   initial begin : stim
      int n;
      RESET = 1'b1;
      va = 2'b11;
      vb = 2'b11;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      n_chk++;
      if ({rdy_a, rv_a, bdir_a, bc_a, di_a, busy_a, rd_a} !== {14'h0, 8'hFF}) begin
         n_fail++;
         $display("FAIL A_reset: got rdy=%b rv=%b bdir=%b bc=%b di=%h busy=%b rd=%h, want zeros rd=ff",
                  rdy_a, rv_a, bdir_a, bc_a, di_a, busy_a, rd_a);
      end
      n_chk++;
      if ({rdy_b, rv_b, bdir_b, bc_b, di_b, busy_b, rd_b} !== {14'h0, 8'hFF}) begin
         n_fail++;
         $display("FAIL B_reset: got rdy=%b rv=%b bdir=%b bc=%b di=%h busy=%b rd=%h, want zeros rd=ff",
                  rdy_b, rv_b, bdir_b, bc_b, di_b, busy_b, rd_b);
      end
      @(posedge CLK); #1;
      va = '0;
      vb = '0;
      RESET = 1'b0;
      repeat (2) @(posedge CLK);

      txn(0, 0, 1, 4'd8, 8'h1F, 8'h00, 0);
      txn(0, 1, 0, 4'd7, 8'h00, 8'hB8, 0);
      txn(0, 0, 1, 4'd13, 8'h05, 8'h00, 0);
      txn(0, 0, 1, 4'd13, 8'h0A, 8'h00, 1);
      txn(0, 1, 0, 4'd13, 8'h00, 8'h3C, 1);

      push_txn(0, 0, 1, 4'd2, 8'h11, 8'h00, 0, 1);
      push_txn(0, 1, 1, 4'd3, 8'h22, 8'h00, 0, 1);
      push_txn(0, 0, 1, 4'd2, 8'h11, 8'h00, 0, 1);
      push_txn(0, 1, 1, 4'd3, 8'h22, 8'h00, 0, 1);
      @(posedge CLK); #1;
      va = 2'b11; wa = 2'b11; aa = {4'd3, 4'd2}; da = {8'h22, 8'h11};
      n = 0;
      for (int i = 0; i < 60 && n < 4; i++) begin
         @(negedge CLK);
         if (|rdy_a) n++;
      end
      n_chk++;
      if (n != 4) begin
         n_fail++;
         $display("FAIL rr_grants: got %0d grants, want 4", n);
      end
      @(posedge CLK); #1;
      va = '0;
      wait_idle(0);

      put(0, '{rdy: 2'b01, bdir: 0, bc: 0, di: 0, rv: 0, rd: 0});
      put(0, '{rdy: 0, bdir: 1, bc: 1, di: 8'h05, rv: 0, rd: 0});
      @(posedge CLK); #1;
      va[0] = 1'b1; wa[0] = 1'b1; aa[3:0] = 4'd5; da[7:0] = 8'h77;
      wait_ready(0, 0);
      @(posedge CLK); #1;
      va = '0;
      RESET = 1'b1;
      @(posedge CLK); #1;
      RESET = 1'b0;
      @(negedge CLK);
      n_chk++;
      if ({bdir_a, bc_a, busy_a, rv_a} !== 5'b0) begin
         n_fail++;
         $display("FAIL abort_bus: got bdir=%b bc=%b busy=%b rv=%b, want all 0",
                  bdir_a, bc_a, busy_a, rv_a);
      end
      repeat (3) @(posedge CLK);
      txn(0, 0, 1, 4'd5, 8'h77, 8'h00, 0);

      txn(1, 0, 0, 4'd14, 8'h00, 8'h5A, 0);
      txn(1, 0, 1, 4'd1, 8'h42, 8'h00, 0);
      txn(1, 1, 0, 4'd1, 8'h00, 8'h5A, 1);

      repeat (5) @(posedge CLK);
      n_chk++;
      if (qa.size() != 0) begin
         n_fail++;
         $display("FAIL A_drain: got %0d records left, want 0", qa.size());
      end
      n_chk++;
      if (qb.size() != 0) begin
         n_fail++;
         $display("FAIL B_drain: got %0d records left, want 0", qb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
